axis_chan_framer: RTL and testbench
===================================

// Module: axis_chan_framer
// PURPOSE
//   Downstream of the channel fan-in. Consumes the merged stream (data, tlast, binary channel id
//   on tuser) and frames each packet for the host DMA path: one header beat (magic, channel,
//   per-channel sequence number), the payload, and an optional trailer. Enforces a payload
//   length limit so a stuck channel cannot hold the link. Registered output, full AXIS handshake.
// PARAMETERS
//   DATA_WIDTH  256   payload/header beat width; must be >= 64
//   NUM_CHAN    6     width of s_axis_tuser, carrying the binary channel number (values 0..NUM_CHAN-1)
//   MAX_BEATS   1024  maximum payload beats per packet; range 2..65535
// PORTS
//   clk            in   1      core clock
//   rst_n          in   1      asynchronous active-low reset
//   s_axis_tvalid  in   1      merged-stream valid
//   s_axis_tready  out  1      merged-stream ready
//   s_axis_tdata   in   DW     payload beat
//   s_axis_tlast   in   1      last payload beat of packet
//   s_axis_tuser   in   NUM_CHAN  binary channel number
//   m_axis_tvalid  out  1      framed-stream valid
//   m_axis_tready  in   1      framed-stream ready
//   m_axis_tdata   out  DW     header / payload / trailer beat
//   m_axis_tlast   out  1      last beat of framed packet
//   err_trunc      out  1      1-cycle pulse: packet truncated at MAX_BEATS
//   err_chan       out  1      1-cycle pulse: tuser changed mid-packet
// BEHAVIOUR
//   - One clock. Reset is asynchronous, active-low. On reset: m_axis_tvalid=0, tdata=0,
//     tlast=0, s_axis_tready=0, err_*=0, state=IDLE, beat count=0, all sequence counters=0.
//   - Single output register. "slot free" = ~m_axis_tvalid | m_axis_tready.
//     A loaded beat holds stable until accepted.
//   - FSM states: IDLE, PAYLOAD, TRAIL (feature only), DROP.
//   - IDLE: s_axis_tready=0. On s_axis_tvalid & slot free:
//     load header, latch chan=s_axis_tuser, clear beat count, go to PAYLOAD.
//     The header appears on m_axis 1 cycle after the first beat is presented.
//   - Header: [15:0]=16'hA5C3; [23:16]=chan, zero-extended; [39:24]=seq[chan]; rest 0; tlast=0.
//     seq[chan] increments when the header is loaded; it wraps 16'hFFFF->0.
//   - PAYLOAD: s_axis_tready = slot free. Each accepted beat is copied to the output register
//     (latency 1), and the beat count increments.
//   - If s_axis_tuser != chan on an accepted beat: pulse err_chan, keep the beat, keep chan.
//   - Accepted beat with s_axis_tlast: output tlast=1 (trailer off) or tlast=0 (trailer on).
//     Next state is IDLE, or TRAIL when the trailer is on.
//   - Accepted beat that is beat MAX_BEATS without s_axis_tlast: output it with the tlast rule
//     above, pulse err_trunc, go to DROP.
//   - DROP: s_axis_tready=1 and input beats are discarded. On an accepted tlast beat go to IDLE
//     (trailer off) or TRAIL (trailer on; the trailer is emitted after the drop completes).
//   - Back-to-back packets: a new header needs IDLE, so there is one idle input cycle per packet.
//   - Reset mid-packet: any partial frame is abandoned with no tlast; the next frame restarts at seq 0.
// CONFIGURATION
//   AXIS_FRAMER_TRAILER_EN defined:
//     - TRAIL loads one trailer beat when the slot is free, with tlast=1, then goes to IDLE.
//     - Trailer: [15:0]=16'h5A3C; [31:16]=payload beats forwarded; [32]=truncated;
//       [33]=chan mismatch seen; rest 0.
//   Undefined: no TRAIL state; the last payload beat carries tlast.
// STRUCTURE
//   axis_framer_pkg.vh:
//     - HDR_MAGIC and TRL_MAGIC
//     - state encodings
//     - header/trailer field offsets
//   Sub-module axis_out_reg: one-entry output register with load/hold and the slot-free
//   output; the FSM drives its load and data.
// TESTING
//   1. Chan 2, 4-beat packet, ready=1:
//      -> header beat 0x..0000_02A5C3 (seq 0), then 4 payload beats; tlast on beat 4; no errors.
//   2. Three packets on chan 2, then one on chan 5:
//      -> chan 2 headers carry seq 0,1,2; chan 5 header carries seq 0; one idle input cycle
//         between packets.
//   3. MAX_BEATS=4, 7-beat packet:
//      -> 4 beats forwarded, tlast on 4th, err_trunc pulses once, beats 5-7 consumed and dropped,
//         next packet is framed normally.
//   4. Random m_axis_tready (50%) over 100 packets:
//      -> output order matches a reference model, tdata stable while stalled, no loss or duplicates.
//   5. tuser switches 1->3 at beat 2:
//      -> err_chan pulses once, all beats forwarded, header chan stays 1.
//   6. rst_n low mid-payload, then a new packet:
//      -> m_axis_tvalid=0 immediately; new header carries seq 0.
//      With AXIS_FRAMER_TRAILER_EN, test 3 trailer reads count=4, truncated=1.

Source files
------------

// File: rtl/axis_chan_framer_pkg.sv
// Shared types and constants for axis_chan_framer.
// AXIS_FRAMER_TRAILER_EN adds the TRAIL state and the trailer beat layout.
package axis_chan_framer_pkg;

    localparam int unsigned SEQ_W = 16;
    localparam int unsigned CNT_W = 16;

    localparam logic [15:0] HDR_MAGIC = 16'hA5C3;

    // Header beat layout, LSB first: magic [15:0], chan [23:16], seq [39:24]
    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [7:0]       chan;
        logic [15:0]      magic;
    } hdr_t;

`ifdef AXIS_FRAMER_TRAILER_EN
    localparam logic [15:0] TRL_MAGIC = 16'h5A3C;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TRAIL   = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    // Trailer beat layout, LSB first: magic [15:0], beats [31:16], trunc [32], mis [33]
    typedef struct packed {
        logic             mis;
        logic             trunc;
        logic [CNT_W-1:0] beats;
        logic [15:0]      magic;
    } trl_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/axis_chan_framer_out_reg.sv
// One-entry AXIS output register: a loaded beat holds until the sink accepts it.
module axis_chan_framer_out_reg #(
    parameter int unsigned DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_slot_free_c
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid       = r_valid;
    assign o_data        = r_data;
    assign o_last        = r_last;
    assign o_slot_free_c = ~r_valid | i_ready;

endmodule

// File: rtl/axis_chan_framer.sv
// Frames merged-stream packets as header + payload (+ trailer when AXIS_FRAMER_TRAILER_EN),
// with per-channel sequence numbers and a MAX_BEATS payload truncation limit.
module axis_chan_framer
    import axis_chan_framer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned NUM_CHAN   = 6,
    parameter int unsigned MAX_BEATS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic [NUM_CHAN-1:0]   s_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  err_trunc,
    output logic                  err_chan
);

`ifdef AXIS_FRAMER_TRAILER_EN
    localparam logic   LAST_ON_PAYLOAD = 1'b0;
    localparam state_t ST_POST         = ST_TRAIL;
`else
    localparam logic   LAST_ON_PAYLOAD = 1'b1;
    localparam state_t ST_POST         = ST_IDLE;
`endif

    state_t                r_state, w_state_nxt;
    logic [NUM_CHAN-1:0]   r_chan;
    logic [CNT_W-1:0]      r_cnt;
    logic [SEQ_W-1:0]      r_seq [NUM_CHAN];
    logic                  r_err_trunc, r_err_chan;

    logic                  w_slot_free;
    logic                  w_load, w_last, w_s_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_hdr_ld, w_beat_acc, w_err_trunc, w_err_chan;
    logic [SEQ_W-1:0]      w_seq_cur;
    hdr_t                  w_hdr;

    // Sequence number of the channel presenting the next packet
    always_comb begin
        w_seq_cur = '0;
        for (int unsigned c = 0; c < NUM_CHAN; c++) begin
            if (s_axis_tuser == NUM_CHAN'(c)) w_seq_cur = r_seq[c];
        end
        w_hdr = '{seq: w_seq_cur, chan: 8'(s_axis_tuser), magic: HDR_MAGIC};
    end

`ifdef AXIS_FRAMER_TRAILER_EN
    logic r_trunc_seen, r_mis_seen;
    trl_t w_trl;

    assign w_trl = '{mis: r_mis_seen, trunc: r_trunc_seen, beats: r_cnt, magic: TRL_MAGIC};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trunc_seen <= 1'b0;
            r_mis_seen   <= 1'b0;
        end else if (w_hdr_ld) begin
            r_trunc_seen <= 1'b0;
            r_mis_seen   <= 1'b0;
        end else begin
            if (w_err_trunc) r_trunc_seen <= 1'b1;
            if (w_err_chan)  r_mis_seen   <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, output-register load and input handshake
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_data      = '0;
        w_last      = 1'b0;
        w_s_ready   = 1'b0;
        w_hdr_ld    = 1'b0;
        w_beat_acc  = 1'b0;
        w_err_trunc = 1'b0;
        w_err_chan  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_axis_tvalid && w_slot_free) begin
                    w_load      = 1'b1;
                    w_data      = DATA_WIDTH'(w_hdr);
                    w_hdr_ld    = 1'b1;
                    w_state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                w_s_ready = w_slot_free;
                if (s_axis_tvalid && w_slot_free) begin
                    w_load     = 1'b1;
                    w_data     = s_axis_tdata;
                    w_beat_acc = 1'b1;
                    w_err_chan = (s_axis_tuser != r_chan);
                    if (s_axis_tlast) begin
                        w_last      = LAST_ON_PAYLOAD;
                        w_state_nxt = ST_POST;
                    end else if (r_cnt == CNT_W'(MAX_BEATS - 1)) begin
                        w_last      = LAST_ON_PAYLOAD;
                        w_err_trunc = 1'b1;
                        w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                w_s_ready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) w_state_nxt = ST_POST;
            end
`ifdef AXIS_FRAMER_TRAILER_EN
            ST_TRAIL: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_data      = DATA_WIDTH'(w_trl);
                    w_last      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chan      <= '0;
            r_cnt       <= '0;
            r_err_trunc <= 1'b0;
            r_err_chan  <= 1'b0;
            for (int unsigned c = 0; c < NUM_CHAN; c++) r_seq[c] <= '0;
        end else begin
            r_err_trunc <= w_err_trunc;
            r_err_chan  <= w_err_chan;
            if (w_hdr_ld) begin
                r_chan <= s_axis_tuser;
                r_cnt  <= '0;
                for (int unsigned c = 0; c < NUM_CHAN; c++) begin
                    if (s_axis_tuser == NUM_CHAN'(c)) r_seq[c] <= r_seq[c] + SEQ_W'(1);
                end
            end else if (w_beat_acc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    axis_chan_framer_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_load),
        .i_data        (w_data),
        .i_last        (w_last),
        .i_ready       (m_axis_tready),
        .o_valid       (m_axis_tvalid),
        .o_data        (m_axis_tdata),
        .o_last        (m_axis_tlast),
        .o_slot_free_c (w_slot_free)
    );

    assign s_axis_tready = w_s_ready;
    assign err_trunc     = r_err_trunc;
    assign err_chan      = r_err_chan;

endmodule

// File: tb/tb_axis_chan_framer.sv
// Directed bench for axis_chan_framer (DATA_WIDTH=64, NUM_CHAN=6, MAX_BEATS=4).
// Expectations follow AXIS_FRAMER_TRAILER_EN when it is defined for the build.
module tb_axis_chan_framer;

    localparam int DW = 64;
    localparam int NC = 6;
    localparam int MB = 4;
`ifdef AXIS_FRAMER_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic [NC-1:0] s_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          err_trunc;
    logic          err_chan;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;
    int          rdy_mode    = 0;
    int          n_trunc     = 0;
    int          n_chan      = 0;
    int          stall_viol  = 0;
    int unsigned t_present   = 0;

    logic [DW-1:0] got_d [$];
    logic          got_l [$];
    int unsigned   rise_q[$];
    int unsigned   acc_q [$];
    logic [DW-1:0] exp_d [$];
    logic          exp_l [$];
    logic [15:0]   mseq  [NC];

    logic          pv, pr, pl;
    logic [DW-1:0] pd;

    axis_chan_framer #(
        .DATA_WIDTH (DW),
        .NUM_CHAN   (NC),
        .MAX_BEATS  (MB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .err_trunc     (err_trunc),
        .err_chan      (err_chan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Sink ready: 0 = always ready, 1 = random 50%, else stalled
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Output monitor on the falling edge: captures transfers, error pulses, stall stability
    always @(negedge clk) begin
        if (!rst_n) begin
            pv <= 1'b0;
            pr <= 1'b0;
        end else begin
            if (m_axis_tvalid && !pv) rise_q.push_back(cyc);
            if (pv && !pr && (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tlast !== pl))
                stall_viol <= stall_viol + 1;
            if (m_axis_tvalid && m_axis_tready) begin
                got_d.push_back(m_axis_tdata);
                got_l.push_back(m_axis_tlast);
            end
            if (err_trunc) n_trunc <= n_trunc + 1;
            if (err_chan)  n_chan  <= n_chan + 1;
            pv <= m_axis_tvalid;
            pr <= m_axis_tready;
            pd <= m_axis_tdata;
            pl <= m_axis_tlast;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, time limit reached");
        $fatal(1);
    end

    function automatic logic [DW-1:0] hdr_word(input int ch, input logic [15:0] sq);
        return {24'h0, sq, 8'(ch), 16'hA5C3};
    endfunction

    function automatic logic [DW-1:0] trl_word(input int cnt, input bit trunc, input bit mis);
        return {30'h0, mis, trunc, 16'(cnt), 16'h5A3C};
    endfunction

    // Expected framed output of one packet
    task automatic model_pkt(input int ch, input int n, input logic [DW-1:0] base, input bit mis);
        int fwd;
        fwd = (n < MB) ? n : MB;
        exp_d.push_back(hdr_word(ch, mseq[ch]));
        exp_l.push_back(1'b0);
        mseq[ch] = mseq[ch] + 16'd1;
        for (int i = 0; i < fwd; i++) begin
            exp_d.push_back(base + DW'(i));
            exp_l.push_back(!TRL && (i == fwd - 1));
        end
        if (TRL) begin
            exp_d.push_back(trl_word(fwd, n > MB, mis));
            exp_l.push_back(1'b1);
        end
    endtask

    // Drive one packet; sw_idx selects a beat carrying tuser=sw_ch instead of ch
    task automatic send_pkt(input int ch, input int n, input logic [DW-1:0] base,
                            input int sw_idx, input int sw_ch);
        int w;
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + DW'(i);
            s_axis_tlast  = (i == n - 1);
            s_axis_tuser  = NC'((i == sw_idx) ? sw_ch : ch);
            if (i == 0) t_present = cyc;
            w = 0;
            @(negedge clk);
            while (!s_axis_tready && w < 500) begin
                w++;
                @(negedge clk);
            end
            if (w >= 500) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout chan %0d beat %0d: tready stayed %b, required 1", ch, i, s_axis_tready);
            end
            @(posedge clk);
            #1;
            acc_q.push_back(cyc);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        for (int c = 0; c < NC; c++) mseq[c] = 16'd0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'h1234;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = NC'(2);
        for (int c = 0; c < NC; c++) mseq[c] = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        vectors++;
        if (m_axis_tdata !== '0) begin miscompares++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
        vectors++;
        if (m_axis_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
        vectors++;
        if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready got %b want 0", s_axis_tready); end
        vectors++;
        if (err_trunc !== 1'b0 || err_chan !== 1'b0) begin
            miscompares++; $display("FAIL reset_err got %b%b want 00", err_trunc, err_chan);
        end
        s_axis_tvalid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int b, r0, w;
        b  = got_d.size();
        r0 = rise_q.size();
        exp_d.delete(); exp_l.delete();
        model_pkt(2, 4, 64'h100, 1'b0);
        send_pkt(2, 4, 64'h100, -1, 0);
        w = 0;
        while ((got_d.size() - b) < exp_d.size() && w < 1000) begin @(posedge clk); w++; end
        repeat (4) @(negedge clk);
        vectors++;
        if (rise_q.size() <= r0) begin
            miscompares++; $display("FAIL single_latency header never appeared, want cycle %0d", t_present + 1);
        end else if (rise_q[r0] !== t_present + 1) begin
            miscompares++; $display("FAIL single_latency header at cycle %0d want %0d", rise_q[r0], t_present + 1);
        end
        vectors++;
        if ((got_d.size() - b) !== exp_d.size()) begin
            miscompares++; $display("FAIL single_count got %0d beats want %0d", got_d.size() - b, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && b + i < got_d.size(); i++) begin
            vectors++;
            if (got_d[b+i] !== exp_d[i] || got_l[b+i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL single_beat%0d got %h/%b want %h/%b", i, got_d[b+i], got_l[b+i], exp_d[i], exp_l[i]);
            end
        end
        vectors++;
        if (n_trunc !== 0 || n_chan !== 0) begin
            miscompares++; $display("FAIL single_err got trunc %0d chan %0d want 0 0", n_trunc, n_chan);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int b, a0, w, pos, gap;
        int len [4] = '{3, 1, 2, 4};
        int ch  [4] = '{2, 2, 2, 5};
        do_reset();
        gap = TRL ? 3 : 2;
        b  = got_d.size();
        a0 = acc_q.size();
        exp_d.delete(); exp_l.delete();
        for (int k = 0; k < 4; k++) begin
            model_pkt(ch[k], len[k], 64'h200 + DW'(k * 16), 1'b0);
            send_pkt(ch[k], len[k], 64'h200 + DW'(k * 16), -1, 0);
        end
        w = 0;
        while ((got_d.size() - b) < exp_d.size() && w < 1000) begin @(posedge clk); w++; end
        repeat (4) @(negedge clk);
        vectors++;
        if ((got_d.size() - b) !== exp_d.size()) begin
            miscompares++; $display("FAIL b2b_count got %0d beats want %0d", got_d.size() - b, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && b + i < got_d.size(); i++) begin
            vectors++;
            if (got_d[b+i] !== exp_d[i] || got_l[b+i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL b2b_beat%0d got %h/%b want %h/%b", i, got_d[b+i], got_l[b+i], exp_d[i], exp_l[i]);
            end
        end
        pos = a0;
        for (int k = 0; k < 3; k++) begin
            pos = pos + len[k];
            vectors++;
            if (acc_q[pos] - acc_q[pos-1] !== gap) begin
                miscompares++;
                $display("FAIL b2b_gap%0d got %0d cycles want %0d", k, acc_q[pos] - acc_q[pos-1], gap);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_trunc();
        int b, w, t0, c0;
        b  = got_d.size();
        t0 = n_trunc;
        c0 = n_chan;
        exp_d.delete(); exp_l.delete();
        model_pkt(0, 7, 64'h700, 1'b0);
        send_pkt(0, 7, 64'h700, -1, 0);
        model_pkt(0, 2, 64'h800, 1'b0);
        send_pkt(0, 2, 64'h800, -1, 0);
        w = 0;
        while ((got_d.size() - b) < exp_d.size() && w < 1000) begin @(posedge clk); w++; end
        repeat (4) @(negedge clk);
        vectors++;
        if ((got_d.size() - b) !== exp_d.size()) begin
            miscompares++; $display("FAIL trunc_count got %0d beats want %0d", got_d.size() - b, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && b + i < got_d.size(); i++) begin
            vectors++;
            if (got_d[b+i] !== exp_d[i] || got_l[b+i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL trunc_beat%0d got %h/%b want %h/%b", i, got_d[b+i], got_l[b+i], exp_d[i], exp_l[i]);
            end
        end
        vectors++;
        if (n_trunc - t0 !== 1) begin
            miscompares++; $display("FAIL trunc_pulses got %0d want 1", n_trunc - t0);
        end
        vectors++;
        if (n_chan - c0 !== 0) begin
            miscompares++; $display("FAIL trunc_chanerr got %0d want 0", n_chan - c0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_chan_switch();
        int b, w, c0;
        b  = got_d.size();
        c0 = n_chan;
        exp_d.delete(); exp_l.delete();
        model_pkt(1, 2, 64'h900, 1'b1);
        send_pkt(1, 2, 64'h900, 1, 3);
        model_pkt(3, 1, 64'hA00, 1'b0);
        send_pkt(3, 1, 64'hA00, -1, 0);
        w = 0;
        while ((got_d.size() - b) < exp_d.size() && w < 1000) begin @(posedge clk); w++; end
        repeat (4) @(negedge clk);
        vectors++;
        if ((got_d.size() - b) !== exp_d.size()) begin
            miscompares++; $display("FAIL chsw_count got %0d beats want %0d", got_d.size() - b, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && b + i < got_d.size(); i++) begin
            vectors++;
            if (got_d[b+i] !== exp_d[i] || got_l[b+i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL chsw_beat%0d got %h/%b want %h/%b", i, got_d[b+i], got_l[b+i], exp_d[i], exp_l[i]);
            end
        end
        vectors++;
        if (n_chan - c0 !== 1) begin
            miscompares++; $display("FAIL chsw_pulses got %0d want 1", n_chan - c0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int b, w, s0, t0, ch, n;
        b  = got_d.size();
        s0 = stall_viol;
        t0 = n_trunc;
        exp_d.delete(); exp_l.delete();
        rdy_mode = 1;
        for (int k = 0; k < 100; k++) begin
            ch = $urandom_range(0, NC - 1);
            n  = $urandom_range(1, MB);
            model_pkt(ch, n, 64'h1_0000 + DW'(k * 16), 1'b0);
            send_pkt(ch, n, 64'h1_0000 + DW'(k * 16), -1, 0);
        end
        w = 0;
        while ((got_d.size() - b) < exp_d.size() && w < 5000) begin @(posedge clk); w++; end
        rdy_mode = 0;
        repeat (4) @(negedge clk);
        vectors++;
        if ((got_d.size() - b) !== exp_d.size()) begin
            miscompares++; $display("FAIL rand_count got %0d beats want %0d", got_d.size() - b, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && b + i < got_d.size(); i++) begin
            vectors++;
            if (got_d[b+i] !== exp_d[i] || got_l[b+i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL rand_beat%0d got %h/%b want %h/%b", i, got_d[b+i], got_l[b+i], exp_d[i], exp_l[i]);
            end
        end
        vectors++;
        if (stall_viol - s0 !== 0) begin
            miscompares++; $display("FAIL rand_stall_stable got %0d changes want 0", stall_viol - s0);
        end
        vectors++;
        if (n_trunc - t0 !== 0) begin
            miscompares++; $display("FAIL rand_trunc got %0d want 0", n_trunc - t0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int b, w, p0;
        bit saw_last;
        p0 = got_d.size();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'hDEAD;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = NC'(2);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (m_axis_tvalid !== 1'b1) begin miscompares++; $display("FAIL rstmid_active got tvalid %b want 1", m_axis_tvalid); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL rstmid_tvalid got %b want 0", m_axis_tvalid); end
        vectors++;
        if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL rstmid_tready got %b want 0", s_axis_tready); end
        saw_last = 1'b0;
        for (int i = p0; i < got_d.size(); i++) if (got_l[i]) saw_last = 1'b1;
        vectors++;
        if (saw_last !== 1'b0) begin miscompares++; $display("FAIL rstmid_partial_tlast got %b want 0", saw_last); end
        s_axis_tvalid = 1'b0;
        for (int c = 0; c < NC; c++) mseq[c] = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        b = got_d.size();
        exp_d.delete(); exp_l.delete();
        model_pkt(2, 3, 64'hB00, 1'b0);
        send_pkt(2, 3, 64'hB00, -1, 0);
        w = 0;
        while ((got_d.size() - b) < exp_d.size() && w < 1000) begin @(posedge clk); w++; end
        repeat (4) @(negedge clk);
        vectors++;
        if ((got_d.size() - b) !== exp_d.size()) begin
            miscompares++; $display("FAIL rstmid_count got %0d beats want %0d", got_d.size() - b, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && b + i < got_d.size(); i++) begin
            vectors++;
            if (got_d[b+i] !== exp_d[i] || got_l[b+i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL rstmid_beat%0d got %h/%b want %h/%b", i, got_d[b+i], got_l[b+i], exp_d[i], exp_l[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_trunc();
        test_chan_switch();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
